nibble_pack_fifo: RTL

Downstream stage of the 4-bit nibble datapath. It consumes the nibble stream (data plus enable-qualified valid), packs consecutive nibble pairs into bytes, and buffers the bytes in a small first-word-fall-through FIFO. Bytes leave through a valid/ready handshake toward the byte-wide consumer.

---
 rtl/nibble_pack_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/nibble_pack_fifo.sv
// Packs pairs of 4-bit nibbles into bytes and queues them in a small
// first-word-fall-through FIFO drained through a valid/ready port.
module nibble_pack_fifo #(
  parameter int DEPTH     = 4,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [3:0]                   data_in,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [7:0]                   data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         half_pending,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    held_q, held_d;
  logic          half_q, half_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    last_q, last_d;

  logic          push, pop, full, push_ok;
  logic [7:0]    push_byte;

  // Handshake: a byte transfers on a rising edge where out_valid and
  // out_ready are both 1; out_valid never depends on out_ready.
  assign full      = (count_q == FULL_CNT);
  assign pop       = (count_q != '0) && out_ready;
  assign push_ok   = push && (!full || pop);

  always_comb begin
    held_d    = held_q;
    half_d    = half_q;
    push      = 1'b0;
    push_byte = 8'h00;
    if (enable) begin
      if (!half_q) begin
        held_d = data_in;
        half_d = 1'b1;
      end else begin
        push      = 1'b1;
        push_byte = LOW_FIRST ? {data_in, held_q} : {held_q, data_in};
        half_d    = 1'b0;
      end
    end else if (flush && half_q) begin
      push      = 1'b1;
      push_byte = LOW_FIRST ? {4'h0, held_q} : {held_q, 4'h0};
      half_d    = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      held_q   <= 4'h0;
      half_q   <= 1'b0;
      ovf_q    <= 1'b0;
      last_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      held_q   <= held_d;
      half_q   <= half_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

  // When empty, show the most recently consumed byte (0 after reset).
  assign data_out     = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign out_valid    = (count_q != '0);
  assign count        = count_q;
  assign half_pending = half_q;
  assign overflow     = ovf_q;

endmodule
